// File: rtl/freq_div_ctrl.sv
// ---------------------------------------------------------------------------
// freq_div_ctrl
//   Run-time controller for a freq_div instance. It owns the divider's clk_en
//   and div_ratio inputs. Ratio changes are taken over a valid/ready handshake
//   and applied only while the divided clock is low and clk_en is held off.
//   This keeps the divided clock free of runt pulses. A level enable
//   starts and stops the divider through the same low-phase sequencing.
//
// Ports
//   clk_ref     in   reference clock (also clocks the freq_div instance)
//   rst         in   asynchronous reset, active-high
//   enable      in   level, 1 = divider should run
//   req_valid   in   new-ratio request valid
//   req_ratio   in   requested ratio (held stable while req_valid=1)
//   req_ready   out  request accepted when req_valid & req_ready
//   div_clk_out in   freq_div clk_out, sampled on clk_ref
//   div_clk_en  out  drives freq_div clk_en
//   div_ratio   out  drives freq_div div_ratio
//   busy        out  1 while a ratio change or stop is in progress
//   err_ratio   out  one-cycle pulse when an accepted request had ratio < 2
// ---------------------------------------------------------------------------
module freq_div_ctrl #(
  parameter int WIDTH         = 3,
  parameter int DEFAULT_RATIO = 2,
  parameter int SETTLE_CYC    = 4,
  parameter int MAX_WAIT      = 16
) (
  input  logic             clk_ref,
  input  logic             rst,
  input  logic             enable,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_ratio,
  output logic             req_ready,
  input  logic             div_clk_out,
  output logic             div_clk_en,
  output logic [WIDTH-1:0] div_ratio,
  output logic             busy,
  output logic             err_ratio
);

  // One counter serves both the low-phase wait and the settle hold, so it is
  // sized for the larger of the two terminal counts.
  localparam int CNT_MAX = (MAX_WAIT > SETTLE_CYC) ? MAX_WAIT : SETTLE_CYC;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] WAIT_LAST   = CW'(MAX_WAIT - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    WAIT_LOW = 2'd2,
    HOLD     = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pending;
  logic             r_chg;
  logic [CW-1:0]    r_cnt;
  logic             r_clk_en;
  logic [WIDTH-1:0] r_ratio;
  logic             r_busy;
  logic             r_err;

  logic w_accept;
  logic w_legal;

  // Ready is the only combinational output; it must drop the moment reset
  // asserts so no request can be taken while the block is held in reset.
  assign req_ready = ((r_state == IDLE) || (r_state == RUN)) & ~rst;
  assign w_accept  = req_valid & req_ready;
  assign w_legal   = (req_ratio >= WIDTH'(2));

  assign div_clk_en = r_clk_en;
  assign div_ratio  = r_ratio;
  assign busy       = r_busy;
  assign err_ratio  = r_err;

  // Single FSM register block. busy is registered alongside each state
  // transition so it tracks WAIT_LOW/HOLD without a decode after the flops.
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_chg     <= 1'b0;
      r_cnt     <= '0;
      r_clk_en  <= 1'b0;
      r_ratio   <= WIDTH'(DEFAULT_RATIO);
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          // Divider is stopped, so a legal ratio can be written directly.
          // Ratio is always >= 2 here, so entering RUN is always safe.
          if (w_accept) begin
            if (w_legal) r_ratio <= req_ratio;
            else         r_err   <= 1'b1;
          end
          if (enable) begin
            r_state  <= RUN;
            r_clk_en <= 1'b1;
          end
        end
        RUN: begin
          // A legal request takes priority over a stop; the stop is still
          // honoured because HOLD re-checks enable on exit.
          if (w_accept && !w_legal) r_err <= 1'b1;
          if (w_accept && w_legal) begin
            r_pending <= req_ratio;
            r_chg     <= 1'b1;
            r_cnt     <= '0;
            r_state   <= WAIT_LOW;
            r_busy    <= 1'b1;
          end else if (!enable) begin
            r_chg   <= 1'b0;
            r_cnt   <= '0;
            r_state <= WAIT_LOW;
            r_busy  <= 1'b1;
          end
        end
        WAIT_LOW: begin
          // Gate the divider off at a low phase, or give up waiting after
          // MAX_WAIT cycles so a stuck-high feedback cannot stall us.
          if (!div_clk_out || (r_cnt == WAIT_LAST)) begin
            r_clk_en <= 1'b0;
            if (r_chg) begin
              r_ratio <= r_pending;
              r_cnt   <= SETTLE_LAST;
              r_state <= HOLD;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HOLD: begin
          // Keep clk_en low for SETTLE_CYC cycles after the new ratio lands.
          if (r_cnt == '0) begin
            r_busy <= 1'b0;
            r_chg  <= 1'b0;
            if (enable) begin
              r_state  <= RUN;
              r_clk_en <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_freq_div_ctrl
//   Self-checking bench for freq_div_ctrl. Expected div_ratio values are
//   pushed to a queue when a request is driven and popped when the DUT
//   output changes. div_clk_out is driven directly by the bench.
// ---------------------------------------------------------------------------
module tb_freq_div_ctrl;

  logic       clk_ref = 1'b0;
  logic       rst;
  logic       enable;
  logic       req_valid;
  logic [2:0] req_ratio;
  logic       req_ready;
  logic       div_clk_out;
  logic       div_clk_en;
  logic [2:0] div_ratio;
  logic       busy;
  logic       err_ratio;

  int checks   = 0;
  int failures = 0;

  logic [2:0] expQ[$];

  freq_div_ctrl #(
    .WIDTH(3), .DEFAULT_RATIO(2), .SETTLE_CYC(4), .MAX_WAIT(16)
  ) dut (
    .clk_ref    (clk_ref),
    .rst        (rst),
    .enable     (enable),
    .req_valid  (req_valid),
    .req_ratio  (req_ratio),
    .req_ready  (req_ready),
    .div_clk_out(div_clk_out),
    .div_clk_en (div_clk_en),
    .div_ratio  (div_ratio),
    .busy       (busy),
    .err_ratio  (err_ratio)
  );

  always #5 clk_ref = ~clk_ref;

  // Advance to just after the next active edge, where inputs are driven.
  task automatic step();
    @(posedge clk_ref);
    #1;
  endtask

  // Wait (bounded) on negedges until div_ratio differs from old.
  task automatic wait_ratio(input logic [2:0] old, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_ref);
      if (div_ratio !== old) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Wait (bounded) on negedges until div_clk_en equals val; n counts negedges.
  task automatic wait_en(input logic val, input int budget, output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_ref);
      n++;
      if (div_clk_en === val) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [2:0] exp;
    rst = 1'b1; enable = 1'b0; req_valid = 1'b0; req_ratio = '0; div_clk_out = 1'b1;
    repeat (3) step();
    checks++; if (div_clk_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_clk_en got=%b exp=0", div_clk_en); end
    checks++; if (div_ratio !== 3'd2) begin failures++; $display("[TB] FAIL reset_ratio got=%0d exp=2", div_ratio); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=0", req_ready); end
    rst = 1'b0;
    @(negedge clk_ref);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL idle_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_idle_load();
    bit ok;
    logic [2:0] exp;
    step();
    req_valid = 1'b1; req_ratio = 3'd6; expQ.push_back(3'd6);
    wait_ratio(3'd2, 4, ok);
    req_valid = 1'b0;
    exp = expQ.pop_front();
    checks++; if (!ok || div_ratio !== exp) begin failures++; $display("[TB] FAIL idle_load_ratio got=%0d exp=%0d", div_ratio, exp); end
    step();
    enable = 1'b1;
    @(negedge clk_ref);
    checks++; if (div_clk_en !== 1'b0) begin failures++; $display("[TB] FAIL enable_early got=%b exp=0", div_clk_en); end
    @(negedge clk_ref);
    checks++; if (div_clk_en !== 1'b1) begin failures++; $display("[TB] FAIL enable_rise got=%b exp=1", div_clk_en); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL run_busy got=%b exp=0", busy); end
  endtask

  task automatic test_run_change();
    bit ok;
    int n;
    logic [2:0] exp;
    step();
    div_clk_out = 1'b1;
    req_valid = 1'b1; req_ratio = 3'd4; expQ.push_back(3'd4);
    step();
    req_valid = 1'b0;
    @(negedge clk_ref);
    checks++; if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL change_ready got=%b exp=0", req_ready); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL change_busy got=%b exp=1", busy); end
    repeat (3) step();
    @(negedge clk_ref);
    checks++; if (div_clk_en !== 1'b1 || div_ratio !== 3'd6) begin failures++; $display("[TB] FAIL wait_high got_en=%b got_ratio=%0d exp_en=1 exp_ratio=6", div_clk_en, div_ratio); end
    step();
    div_clk_out = 1'b0;
    wait_ratio(3'd6, 4, ok);
    exp = expQ.pop_front();
    checks++; if (!ok || div_ratio !== exp) begin failures++; $display("[TB] FAIL change_ratio got=%0d exp=%0d", div_ratio, exp); end
    checks++; if (div_clk_en !== 1'b0) begin failures++; $display("[TB] FAIL change_en_fall got=%b exp=0", div_clk_en); end
    wait_en(1'b1, 20, ok, n);
    checks++; if (!ok || n != 4) begin failures++; $display("[TB] FAIL settle_cycles got=%0d exp=4 ok=%b", n, ok); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL settle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_forced_change();
    bit ok;
    int n;
    logic [2:0] exp;
    step();
    div_clk_out = 1'b1;
    req_valid = 1'b1; req_ratio = 3'd7; expQ.push_back(3'd7);
    step();
    req_valid = 1'b0;
    @(negedge clk_ref);
    wait_en(1'b0, 40, ok, n);
    checks++; if (!ok || n != 16) begin failures++; $display("[TB] FAIL forced_cycles got=%0d exp=16 ok=%b", n, ok); end
    exp = expQ.pop_front();
    checks++; if (div_ratio !== exp) begin failures++; $display("[TB] FAIL forced_ratio got=%0d exp=%0d", div_ratio, exp); end
    wait_en(1'b1, 20, ok, n);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL forced_resume got=%b exp=1", div_clk_en); end
  endtask

  task automatic test_simultaneous();
    bit ok;
    int n;
    logic [2:0] exp;
    step();
    div_clk_out = 1'b0;
    req_valid = 1'b1; req_ratio = 3'd5; enable = 1'b0; expQ.push_back(3'd5);
    step();
    req_valid = 1'b0;
    wait_ratio(3'd7, 8, ok);
    exp = expQ.pop_front();
    checks++; if (!ok || div_ratio !== exp) begin failures++; $display("[TB] FAIL simul_ratio got=%0d exp=%0d", div_ratio, exp); end
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      @(negedge clk_ref);
      n++;
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL simul_busy got=%b exp=0", busy); end
    repeat (3) @(negedge clk_ref);
    checks++; if (div_clk_en !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("[TB] FAIL simul_idle got_en=%b got_ready=%b exp_en=0 exp_ready=1", div_clk_en, req_ready); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp;
    step();
    req_valid = 1'b1; req_ratio = 3'd3; expQ.push_back(3'd3);
    step();
    req_ratio = 3'd6; expQ.push_back(3'd6);
    @(negedge clk_ref);
    exp = expQ.pop_front();
    checks++; if (div_ratio !== exp) begin failures++; $display("[TB] FAIL b2b_first got=%0d exp=%0d", div_ratio, exp); end
    step();
    req_ratio = 3'd0;
    @(negedge clk_ref);
    exp = expQ.pop_front();
    checks++; if (div_ratio !== exp) begin failures++; $display("[TB] FAIL b2b_second got=%0d exp=%0d", div_ratio, exp); end
    step();
    req_valid = 1'b0;
    @(negedge clk_ref);
    checks++; if (err_ratio !== 1'b1 || div_ratio !== 3'd6) begin failures++; $display("[TB] FAIL idle_illegal got_err=%b got_ratio=%0d exp_err=1 exp_ratio=6", err_ratio, div_ratio); end
  endtask

  task automatic test_illegal();
    step();
    enable = 1'b1;
    step();
    req_valid = 1'b1; req_ratio = 3'd1;
    @(negedge clk_ref);
    checks++; if (err_ratio !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("[TB] FAIL illegal_pre got_err=%b got_ready=%b exp_err=0 exp_ready=1", err_ratio, req_ready); end
    step();
    req_valid = 1'b0;
    @(negedge clk_ref);
    checks++; if (err_ratio !== 1'b1) begin failures++; $display("[TB] FAIL illegal_pulse got=%b exp=1", err_ratio); end
    checks++; if (div_ratio !== 3'd6 || busy !== 1'b0 || div_clk_en !== 1'b1) begin failures++; $display("[TB] FAIL illegal_state got_ratio=%0d got_busy=%b got_en=%b exp=6/0/1", div_ratio, busy, div_clk_en); end
    @(negedge clk_ref);
    checks++; if (err_ratio !== 1'b0 || div_clk_en !== 1'b1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL illegal_after got_err=%b got_en=%b got_busy=%b exp=0/1/0", err_ratio, div_clk_en, busy); end
  endtask

  task automatic test_reset_mid_run();
    step();
    checks++; if (div_clk_en !== 1'b1) begin failures++; $display("[TB] FAIL midrun_pre got=%b exp=1", div_clk_en); end
    rst = 1'b1;
    #1;
    checks++; if (div_clk_en !== 1'b0 || div_ratio !== 3'd2) begin failures++; $display("[TB] FAIL midrun_reset got_en=%b got_ratio=%0d exp_en=0 exp_ratio=2", div_clk_en, div_ratio); end
    checks++; if (busy !== 1'b0 || req_ready !== 1'b0) begin failures++; $display("[TB] FAIL midrun_flags got_busy=%b got_ready=%b exp=0/0", busy, req_ready); end
    step();
    rst = 1'b0;
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_load();
    test_run_change();
    test_forced_change();
    test_simultaneous();
    test_back_to_back();
    test_illegal();
    test_reset_mid_run();
    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
